// File: rtl/pattern_merge_chain.sv
// ---------------------------------------------------------------------------
// pattern_merge_chain
//   A cascade of DEPTH registered pattern stages on a W-bit channel, moved by a
//   valid/ready handshake with full backpressure. Each stage applies the
//   transform selected by the mode that travels with its word:
//     0: ~(x | rotl(x))   1: ~(x & rotl(x))   2: x   3: x ^ (x >> 1)
//   A rolling signature and a saturating counter track accepted outputs.
//
// Ports
//   blif_clk_net    in   1      clock, rising edge
//   blif_reset_net  in   1      asynchronous, active-high reset
//   in_data         in   W      input word
//   in_mode         in   2      transform select, travels with in_data
//   in_valid        in   1      input word present
//   in_ready        out  1      chain accepts a word this cycle
//   out_data        out  W      word held in the last stage
//   out_valid       out  1      out_data is valid
//   out_ready       in   1      downstream accepts out_data
//   flush           in   1      synchronous discard of all in-flight words
//   sig             out  W      rolling signature of accepted outputs
//   xfer_cnt        out  CNT_W  saturating count of output handshakes
// ---------------------------------------------------------------------------
module pattern_merge_chain #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [W-1:0]     sig,
  output logic [CNT_W-1:0] xfer_cnt
);

  function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]};
  endfunction

  function automatic logic [W-1:0] xform(input logic [1:0] mode,
                                         input logic [W-1:0] x);
    logic [W-1:0] res;
    case (mode)
      2'd0:    res = ~(x | rotl1(x));
      2'd1:    res = ~(x & rotl1(x));
      2'd2:    res = x;
      default: res = x ^ (x >> 1);
    endcase
    return res;
  endfunction

  // Per-stage state: valid flag, word and the mode it carries.
  logic [DEPTH-1:0] v_q, v_d;
  logic [W-1:0]     d_q [DEPTH];
  logic [W-1:0]     d_d [DEPTH];
  logic [1:0]       m_q [DEPTH];
  logic [1:0]       m_d [DEPTH];
  logic [W-1:0]     sig_q, sig_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  // rdy[k]: stage k can take a word this cycle (it is empty or drains too).
  logic [DEPTH:0] rdy;
  logic           in_accept;
  logic           out_hs;

  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
  end

  // Flush masks acceptance, so a word offered during a flush stays with the
  // source. in_ready is combinational on out_ready: there is no skid buffer.
  assign in_ready  = rdy[0] & ~flush;
  assign in_accept = in_valid & in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_hs    = out_valid & out_ready;
  assign sig       = sig_q;
  assign xfer_cnt  = xfer_cnt_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    v_d        = v_q;
    d_d        = d_q;
    m_d        = m_q;
    sig_d      = sig_q;
    xfer_cnt_d = xfer_cnt_q;

    // Stage 0: loads from the input, otherwise empties when its word moves on.
    if (in_accept) begin
      v_d[0] = 1'b1;
      d_d[0] = xform(in_mode, in_data);
      m_d[0] = in_mode;
    end else if (v_q[0] && rdy[1]) begin
      v_d[0] = 1'b0;
    end

    // Stage k: loads from stage k-1, otherwise empties when its word moves on.
    for (int k = 1; k < DEPTH; k++) begin
      if (v_q[k-1] && rdy[k]) begin
        v_d[k] = 1'b1;
        d_d[k] = xform(m_q[k-1], d_q[k-1]);
        m_d[k] = m_q[k-1];
      end else if (v_q[k] && rdy[k+1]) begin
        v_d[k] = 1'b0;
      end
    end

    // The handshake still counts in a flush cycle; only the words are dropped.
    if (out_hs) begin
      sig_d = rotl1(sig_q) ^ d_q[DEPTH-1];
      if (xfer_cnt_q != '1) begin
        xfer_cnt_d = xfer_cnt_q + 1'b1;
      end
    end

    if (flush) begin
      v_d = '0;
    end
  end

  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      v_q        <= '0;
      // NOTE: the data and mode registers are reset as well, so out_data
      // reads 0 after reset rather than whatever a previous run left behind.
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
        m_q[k] <= '0;
      end
      sig_q      <= '0;
      xfer_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every stage samples the values
      // of its neighbour from before this edge.
      v_q        <= v_d;
      d_q        <= d_d;
      m_q        <= m_d;
      sig_q      <= sig_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_pattern_merge_chain.sv
// ---------------------------------------------------------------------------
// tb_pattern_merge_chain
//   Directed bench for pattern_merge_chain (W=8, DEPTH=4, CNT_W=16), with a
//   second instance at CNT_W=4 for counter saturation and mid-cycle reset.
//   Expected words are computed when an input is accepted and queued; they are
//   popped and compared at each output handshake.
// ---------------------------------------------------------------------------
module tb_pattern_merge_chain;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic [1:0]   in_mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         flush;
  logic [W-1:0] sig;
  logic [15:0]  xfer_cnt;

  logic         s_rst;
  logic [W-1:0] s_in_data;
  logic [1:0]   s_in_mode;
  logic         s_in_valid;
  logic         s_in_ready;
  logic [W-1:0] s_out_data;
  logic         s_out_valid;
  logic         s_out_ready;
  logic         s_flush;
  logic [W-1:0] s_sig;
  logic [3:0]   s_xfer_cnt;

  pattern_merge_chain #(.W(W), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .in_data        (in_data),
    .in_mode        (in_mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .flush          (flush),
    .sig            (sig),
    .xfer_cnt       (xfer_cnt)
  );

  pattern_merge_chain #(.W(W), .DEPTH(DEPTH), .CNT_W(4)) u_sat (
    .blif_clk_net   (clk),
    .blif_reset_net (s_rst),
    .in_data        (s_in_data),
    .in_mode        (s_in_mode),
    .in_valid       (s_in_valid),
    .in_ready       (s_in_ready),
    .out_data       (s_out_data),
    .out_valid      (s_out_valid),
    .out_ready      (s_out_ready),
    .flush          (s_flush),
    .sig            (s_sig),
    .xfer_cnt       (s_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] model_sig;
  logic [15:0]  model_cnt;
  logic         last_acc;
  int           n_acc;

  function automatic logic [W-1:0] tf(input logic [1:0] m, input logic [W-1:0] x);
    logic [W-1:0] r;
    r = {x[W-2:0], x[W-1]};
    case (m)
      2'd0:    return ~(x | r);
      2'd1:    return ~(x & r);
      2'd2:    return x;
      default: return x ^ {1'b0, x[W-1:1]};
    endcase
  endfunction

  function automatic logic [W-1:0] tf_chain(input logic [1:0] m, input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x;
    for (int i = 0; i < DEPTH; i++) y = tf(m, y);
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs are already driven. Sample away from the edge, update
  // the scoreboard, advance through the edge, then check sig/xfer_cnt.
  task automatic step();
    logic [W-1:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("out_without_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
        model_sig = {model_sig[W-2:0], model_sig[W-1]} ^ e;
        if (model_cnt != 16'hFFFF) model_cnt++;
      end
    end
    if (flush) exp_q.delete();
    if (last_acc) begin
      exp_q.push_back(tf_chain(in_mode, in_data));
      n_acc++;
    end
    @(posedge clk);
    #1;
    chk("sig", 32'(sig), 32'(model_sig));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(model_cnt));
  endtask

  // Steps until out_valid is seen; returns edges since the accept edge.
  task automatic wait_out(output int edges);
    edges = 1;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  int lat;
  int guard;

  initial begin
    rst = 1'b1; in_data = '0; in_mode = '0; in_valid = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
    s_rst = 1'b1; s_in_data = 8'h3C; s_in_mode = 2'd2; s_in_valid = 1'b0;
    s_out_ready = 1'b1; s_flush = 1'b0;
    model_sig = '0; model_cnt = '0; n_acc = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #2 rst = 1'b0; s_rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sig", 32'(sig), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);

    // Pass mode: 0xA5, mode 2, 4-cycle latency
    out_ready = 1'b1;
    in_data = 8'hA5; in_mode = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("pass_latency", 32'(lat), 32'd4);
    chk("pass_out_data", 32'(out_data), 32'hA5);
    step();
    chk("pass_sig", 32'(sig), 32'hA5);
    chk("pass_cnt", 32'(xfer_cnt), 32'd1);

    // XOR mode: 0x80 -> C0, A0, F0, 88
    in_data = 8'h80; in_mode = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("xor_out_data", 32'(out_data), 32'h88);
    step();
    chk("xor_sig", 32'(sig), 32'hC3);
    chk("xor_cnt", 32'(xfer_cnt), 32'd2);

    // NOR then NAND back-to-back; in_mode toggles while they are in flight
    in_data = 8'h00; in_mode = 2'd0; in_valid = 1'b1;
    step();
    in_data = 8'hFF; in_mode = 2'd1;
    step();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      in_mode = in_mode ^ 2'd3;
      step();
      guard++;
    end
    chk("nor_out_valid", 32'(out_valid), 32'd1);
    chk("nor_out_data", 32'(out_data), 32'h00);
    in_mode = 2'd3;
    step();
    chk("nand_out_valid", 32'(out_valid), 32'd1);
    chk("nand_out_data", 32'(out_data), 32'hFF);
    step();
    chk("mix_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: 6 offers with out_ready low, only DEPTH accepted
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i * 37 + 5); in_mode = 2'(i); in_valid = 1'b1;
      step();
    end
    chk("bp_accepted", 32'(n_acc), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    step();
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", 32'(out_data), 32'(exp_q[0]));
    // Full chain with out_ready high accepts and emits in the same cycle
    out_ready = 1'b1;
    in_data = 8'h5A; in_mode = 2'd3; in_valid = 1'b1;
    step();
    chk("full_pass_through_acc", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0) && guard < 20) begin
      step();
      guard++;
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);

    // Flush: 3 words in flight, flush together with in_valid
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h11 << i); in_mode = 2'(i); in_valid = 1'b1;
      step();
    end
    in_data = 8'hE7; in_mode = 2'd1; flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("flush_not_accepted", 32'(last_acc), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    in_data = 8'h3C; in_mode = 2'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    chk("flush_new_latency", 32'(lat), 32'd4);
    step();

    // Flush while a handshake completes: the handshake still counts
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hC3 ^ i); in_mode = 2'd2; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_hs_out_valid", 32'(out_valid), 32'd0);
    chk("flush_hs_cnt", 32'(xfer_cnt), 32'(model_cnt));

    // Saturation (CNT_W=4) and asynchronous reset between edges
    s_in_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(s_xfer_cnt), 32'd15);
    chk("sat_out_valid", 32'(s_out_valid), 32'd1);
    @(posedge clk);
    #3 s_rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(s_out_valid), 32'd0);
    chk("async_rst_sig", 32'(s_sig), 32'd0);
    chk("async_rst_cnt", 32'(s_xfer_cnt), 32'd0);
    chk("async_rst_out_data", 32'(s_out_data), 32'd0);
    s_in_valid = 1'b0;
    @(posedge clk); #2 s_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
